// File: rtl/csa_seq_adder.sv
// Multi-cycle wide adder: one WIDTH-bit conditional sum adder reused across CHUNKS slices.
// Optional subtract mode is enabled by defining CSA_SEQ_SUB_EN (adds a 'sub' input).

module csa #(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] sum,
    output logic             co
);
    logic [WIDTH:0] res0;
    logic [WIDTH:0] res1;

    // Both carry-in outcomes are formed up front; the real carry only selects.
    always_comb begin
        res0 = (WIDTH+1)'(a) + (WIDTH+1)'(b);
        res1 = res0 + (WIDTH+1)'(1);
        {co, sum} = ci ? res1 : res0;
    end
endmodule

module csa_seq_adder #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned CHUNKS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [WIDTH*CHUNKS-1:0] a,
    input  logic [WIDTH*CHUNKS-1:0] b,
    input  logic                    ci,
`ifdef CSA_SEQ_SUB_EN
    input  logic                    sub,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH*CHUNKS-1:0] sum,
    output logic                    co
);
    localparam int unsigned N    = WIDTH * CHUNKS;
    localparam int unsigned IDXW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [IDXW-1:0]   idx, idx_next;
    logic              carry, carry_next;
    logic [N-1:0]      op_a, op_a_next;
    logic [N-1:0]      op_b, op_b_next;
    logic [N-1:0]      sum_next;
    logic              co_next;
    logic [WIDTH-1:0]  slice_a, slice_b, slice_sum;
    logic              slice_co;
    int unsigned       offset;

    assign offset  = 32'(idx) * WIDTH;
    assign slice_a = op_a[offset +: WIDTH];
    assign slice_b = op_b[offset +: WIDTH];

    csa #(.WIDTH(WIDTH)) u_csa (
        .a   (slice_a),
        .b   (slice_b),
        .ci  (carry),
        .sum (slice_sum),
        .co  (slice_co)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            sum   <= '0;
            co    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            carry <= carry_next;
            op_a  <= op_a_next;
            op_b  <= op_b_next;
            sum   <= sum_next;
            co    <= co_next;
            busy  <= (state_next == ADD);
            done  <= (state_next == DONE);
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        carry_next = carry;
        op_a_next  = op_a;
        op_b_next  = op_b;
        sum_next   = sum;
        co_next    = co;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ADD;
                    idx_next   = '0;
                    op_a_next  = a;
                    op_b_next  = b;
                    carry_next = ci;
                    sum_next   = '0;
`ifdef CSA_SEQ_SUB_EN
                    // Two's-complement subtract: invert b and force the carry-in.
                    if (sub) begin
                        op_b_next  = ~b;
                        carry_next = 1'b1;
                    end
`endif
                end
            end
            ADD: begin
                sum_next[offset +: WIDTH] = slice_sum;
                carry_next                = slice_co;
                if (idx == IDX_LAST) begin
                    state_next = DONE;
                    co_next    = slice_co;
                    idx_next   = '0;
                end else begin
                    idx_next = idx + IDXW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_csa_seq_adder.sv
// Scoreboard bench for csa_seq_adder: stimulus queues expected {co,sum}, a monitor checks on done.
// Subtract vectors are included when CSA_SEQ_SUB_EN is defined.

module tb_csa_seq_adder;
    localparam int unsigned WIDTH  = 3;
    localparam int unsigned CHUNKS = 4;
    localparam int unsigned N      = WIDTH * CHUNKS;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] a, b;
    logic         ci;
    logic         sub;
    logic         busy, done;
    logic [N-1:0] sum;
    logic         co;

    int errors = 0;
    int checks = 0;
    logic [N:0] exp_q[$];

    always #5 clk = ~clk;

    csa_seq_adder #(.WIDTH(WIDTH), .CHUNKS(CHUNKS)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
`ifdef CSA_SEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .co    (co)
    );

    task automatic check(input string name, input logic [N:0] act, input logic [N:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got {co,sum}=0x%0h expected no done", {co, sum});
            end else begin
                check("result", {co, sum}, exp_q.pop_front());
            end
        end
    end

    task automatic start_op(input logic [N-1:0] ta, input logic [N-1:0] tb_, input logic tci,
                            input logic tsub);
        logic [N:0] e;
        a = ta; b = tb_; ci = tci; sub = tsub; start = 1'b1;
        if (tsub) e = (N+1)'(ta) + (N+1)'(~tb_) + (N+1)'(1);
        else      e = (N+1)'(ta) + (N+1)'(tb_) + (N+1)'(tci);
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        logic seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 20 cycles");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int loops;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_sum", (N+1)'(sum), '0);
        check("reset_co", (N+1)'(co), '0);
        check("reset_busy", (N+1)'(busy), '0);
        check("reset_done", (N+1)'(done), '0);
        @(posedge clk); #1;

        // Latency: busy for 4 cycles, done in the 5th cycle after the start edge.
        start_op(12'h7FF, 12'h001, 1'b0, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(negedge clk);
            else       @(negedge clk);
            check($sformatf("busy_c%0d", c), (N+1)'(busy), (N+1)'(c <= 4));
            check($sformatf("done_c%0d", c), (N+1)'(done), (N+1)'(c == 5));
        end
        @(posedge clk); #1;

        start_op(12'hFFF, 12'hFFF, 1'b1, 1'b0);
        wait_done();
        a = '0; b = '0; ci = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_result", {co, sum}, 13'h1FFF);
        @(posedge clk); #1;
        start_op(12'h000, 12'h000, 1'b0, 1'b0);
        wait_done();

        // start held high through ADD/DONE: only accepted again once back in IDLE.
        a = 12'h123; b = 12'h456; ci = 1'b0; start = 1'b1;
        exp_q.push_back(13'h0579);
        exp_q.push_back(13'h1FFE);
        @(posedge clk); #1;
        a = 12'hFFF; b = 12'hFFF;
        wait_done();
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();

        // Reset in the second ADD cycle aborts the operation.
        start_op(12'h0AA, 12'h055, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_busy", (N+1)'(busy), '0);
        check("abort_done", (N+1)'(done), '0);
        check("abort_result", {co, sum}, '0);
        repeat (8) @(posedge clk);
        #1;
        start_op(12'h001, 12'h001, 1'b0, 1'b0);
        wait_done();

        loops = 0;
        for (int i = 0; i < 1000; i++) begin
            start_op(N'($urandom_range(0, 4095)), N'($urandom_range(0, 4095)),
                     1'($urandom_range(0, 1)), 1'b0);
            wait_done();
            loops++;
        end
        check("random_loop_count", (N+1)'(loops), (N+1)'(1000));

`ifdef CSA_SEQ_SUB_EN
        start_op(12'h005, 12'h007, 1'b0, 1'b1);
        wait_done();
        start_op(12'h007, 12'h005, 1'b0, 1'b1);
        wait_done();
        start_op(12'h100, 12'h0FF, 1'b1, 1'b0);
        wait_done();
`endif

        check("queue_drained", (N+1)'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
